// File: rtl/trace_recorder_pkg.sv
// Shared types and default sizes for the run-length trace recorder.
package trace_recorder_pkg;

    localparam int OUT_LEN_DEF = 7;
    localparam int CNT_W_DEF   = 8;
    localparam int DEPTH_DEF   = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // The value sits in the MSBs so a packed record matches rec_data directly.
    typedef struct packed {
        logic [OUT_LEN_DEF-1:0] value;
        logic [CNT_W_DEF-1:0]   count;
    } rec_t;

endpackage

// File: rtl/rec_fifo.sv
// Synchronous record FIFO with occupancy count; the head word reads as zero when empty.
module rec_fifo #(
    parameter int W     = 15,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a record when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

endmodule

// File: rtl/trace_recorder.sv
// Run-length encodes sampled FSM output words into {value, count} records
// and buffers them in a FIFO for a valid/ready consumer.
module trace_recorder
    import trace_recorder_pkg::*;
#(
    parameter int OUT_LEN = OUT_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_en,
    input  logic [OUT_LEN-1:0]         obs,
    input  logic                       flush,
    output logic                       rec_valid,
    input  logic                       rec_ready,
    output logic [OUT_LEN+CNT_W-1:0]   rec_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);

    localparam int REC_W = OUT_LEN + CNT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    logic [OUT_LEN-1:0] run_val;
    logic [CNT_W-1:0]   run_cnt;
    logic               flush_pend;
    logic               brk;
    logic               push;
    logic [REC_W-1:0]   push_data;
    logic               pop;
    logic               full;
    logic               empty;

    assign brk = (obs != run_val) || (run_cnt == CNT_MAX);
    assign pop = rec_valid && rec_ready;
    assign rec_valid = !empty;

    always_comb begin
        push      = 1'b0;
        push_data = {run_val, run_cnt};
        if (flush_pend) begin
            push = 1'b1;
        end else if (state == RUN && sample_en) begin
            if (brk) begin
                push = 1'b1;
            end else if (flush) begin
                push      = 1'b1;
                push_data = {run_val, run_cnt + 1'b1};
            end
        end else if (state == RUN && flush) begin
            push = 1'b1;
        end else if (state == IDLE && sample_en && flush) begin
            // The sample opens a one-long run that the flush closes at once.
            push      = 1'b1;
            push_data = {obs, CNT_W'(1)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            run_val    <= '0;
            run_cnt    <= '0;
            flush_pend <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
            if (flush_pend) begin
                // Second half of a flush that coincided with a run break.
                state      <= IDLE;
                flush_pend <= 1'b0;
            end else if (sample_en) begin
                if (state == IDLE) begin
                    if (!flush) begin
                        state   <= RUN;
                        run_val <= obs;
                        run_cnt <= CNT_W'(1);
                    end
                end else if (brk) begin
                    run_val <= obs;
                    run_cnt <= CNT_W'(1);
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                end else if (flush) begin
                    state <= IDLE;
                end else begin
                    run_cnt <= run_cnt + 1'b1;
                end
            end else if (flush && state == RUN) begin
                state <= IDLE;
            end
        end
    end

    rec_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (rec_data),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

endmodule

// File: tb/tb_trace_recorder.sv
// Scenario tasks plus a randomized run checked against a queue-based reference model.
module tb_trace_recorder;
    import trace_recorder_pkg::*;

    localparam int OL = 7;
    localparam int CW = 8;
    localparam int DP = 16;
    localparam int RW = OL + CW;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sample_en = 1'b0;
    logic [OL-1:0] obs = '0;
    logic          flush = 1'b0;
    logic          rec_ready = 1'b0;
    logic          rec_valid;
    logic [RW-1:0] rec_data;
    logic [4:0]    level;
    logic          overflow;

    int total = 0;
    int bad = 0;

    // Reference model: open run as plain numbers, FIFO as a queue.
    logic [RW-1:0] exp_q[$];
    bit            m_open;
    bit            m_pend;
    bit            m_ovf;
    logic [OL-1:0] m_val;
    int            m_cnt;

    always #5 clk = ~clk;

    trace_recorder #(
        .OUT_LEN (OL),
        .CNT_W   (CW),
        .DEPTH   (DP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .obs       (obs),
        .flush     (flush),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_data  (rec_data),
        .level     (level),
        .overflow  (overflow)
    );

    function automatic logic [RW-1:0] mk(input logic [OL-1:0] v, input int c);
        rec_t r;
        r.value = v;
        r.count = CW'(c);
        return r;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_open = 0;
        m_pend = 0;
        m_ovf  = 0;
        m_val  = '0;
        m_cnt  = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sample_en = 1'b0;
        flush = 1'b0;
        rec_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    // Drive one cycle of inputs, advance the model across the edge, settle.
    task automatic step(input logic se, input logic [OL-1:0] o, input logic fl, input logic rdy);
        logic [RW-1:0] em[$];
        bit pop_now;
        bit was_full;
        sample_en = se;
        obs = o;
        flush = fl;
        rec_ready = rdy;
        pop_now  = (exp_q.size() > 0) && rdy;
        was_full = (exp_q.size() == DP);
        if (m_pend) begin
            em.push_back(mk(m_val, m_cnt));
            m_open = 0;
            m_pend = 0;
        end else begin
            if (se) begin
                if (!m_open) begin
                    m_open = 1;
                    m_val = o;
                    m_cnt = 1;
                end else if (o == m_val && m_cnt < CMAX) begin
                    m_cnt++;
                end else begin
                    em.push_back(mk(m_val, m_cnt));
                    m_val = o;
                    m_cnt = 1;
                end
            end
            if (fl && m_open) begin
                if (em.size() == 0) begin
                    em.push_back(mk(m_val, m_cnt));
                    m_open = 0;
                end else begin
                    m_pend = 1;
                end
            end
        end
        @(posedge clk);
        if (pop_now) void'(exp_q.pop_front());
        foreach (em[i]) begin
            if (!was_full || pop_now) exp_q.push_back(em[i]);
            else m_ovf = 1;
        end
        #1;
    endtask

    task automatic test_reset();
        total++; if (rec_valid !== 1'b0) begin $display("FAIL reset_valid got=%0b exp=0", rec_valid); bad++; end
        total++; if (level !== 5'd0) begin $display("FAIL reset_level got=%0d exp=0", level); bad++; end
        total++; if (rec_data !== '0) begin $display("FAIL reset_data got=%h exp=0", rec_data); bad++; end
        total++; if (overflow !== 1'b0) begin $display("FAIL reset_overflow got=%0b exp=0", overflow); bad++; end
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 7'h05, 0, 0);
        step(1, 7'h12, 0, 0);
        step(0, 7'h00, 1, 0);
        total++; if (level !== 5'd2) begin $display("FAIL basic_level got=%0d exp=2", level); bad++; end
        total++; if (overflow !== 1'b0) begin $display("FAIL basic_overflow got=%0b exp=0", overflow); bad++; end
        total++; if (rec_data !== mk(7'h05, 3)) begin $display("FAIL basic_rec0 got=%h exp=%h", rec_data, mk(7'h05, 3)); bad++; end
        step(0, 7'h00, 0, 1);
        total++; if (rec_data !== mk(7'h12, 1)) begin $display("FAIL basic_rec1 got=%h exp=%h", rec_data, mk(7'h12, 1)); bad++; end
        step(0, 7'h00, 0, 1);
        total++; if (rec_valid !== 1'b0 || level !== 5'd0) begin $display("FAIL basic_drain got=%0b/%0d exp=0/0", rec_valid, level); bad++; end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 300; i++) step(1, 7'h7F, 0, 0);
        step(0, 7'h00, 1, 0);
        total++; if (level !== 5'd2) begin $display("FAIL sat_level got=%0d exp=2", level); bad++; end
        total++; if (rec_data !== mk(7'h7F, 255)) begin $display("FAIL sat_rec0 got=%h exp=%h", rec_data, mk(7'h7F, 255)); bad++; end
        step(0, 7'h00, 0, 1);
        total++; if (rec_data !== mk(7'h7F, 45)) begin $display("FAIL sat_rec1 got=%h exp=%h", rec_data, mk(7'h7F, 45)); bad++; end
    endtask

    task automatic test_gaps();
        do_reset();
        for (int i = 0; i < 10; i++) step((i % 2) == 0, 7'h0A, 0, 0);
        step(0, 7'h00, 1, 0);
        total++; if (level !== 5'd1) begin $display("FAIL gaps_level got=%0d exp=1", level); bad++; end
        total++; if (rec_data !== mk(7'h0A, 5)) begin $display("FAIL gaps_rec got=%h exp=%h", rec_data, mk(7'h0A, 5)); bad++; end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 17; i++) step(1, OL'(i % 2), 0, 0);
        total++; if (level !== 5'd16) begin $display("FAIL full_level got=%0d exp=16", level); bad++; end
        step(1, 7'h05, 0, 1);
        total++; if (level !== 5'd16) begin $display("FAIL fullpp_level got=%0d exp=16", level); bad++; end
        total++; if (overflow !== 1'b0) begin $display("FAIL fullpp_overflow got=%0b exp=0", overflow); bad++; end
        total++; if (rec_data !== mk(7'h01, 1)) begin $display("FAIL fullpp_head got=%h exp=%h", rec_data, mk(7'h01, 1)); bad++; end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 17; i++) step(1, OL'(i % 2), 0, 0);
        step(0, 7'h00, 1, 0);
        total++; if (level !== 5'd16) begin $display("FAIL ovf_level got=%0d exp=16", level); bad++; end
        total++; if (overflow !== 1'b1) begin $display("FAIL ovf_flag got=%0b exp=1", overflow); bad++; end
        total++; if (rec_data !== mk(7'h00, 1)) begin $display("FAIL ovf_head got=%h exp=%h", rec_data, mk(7'h00, 1)); bad++; end
        step(0, 7'h00, 0, 1);
        total++; if (level !== 5'd15 || overflow !== 1'b1) begin $display("FAIL ovf_sticky got=%0d/%0b exp=15/1", level, overflow); bad++; end
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < 4; i++) step(1, 7'h33, 0, 0);
        do_reset();
        total++; if (rec_valid !== 1'b0 || level !== 5'd0) begin $display("FAIL midrst_clear got=%0b/%0d exp=0/0", rec_valid, level); bad++; end
        total++; if (overflow !== 1'b0) begin $display("FAIL midrst_overflow got=%0b exp=0", overflow); bad++; end
        step(1, 7'h33, 0, 0);
        step(0, 7'h00, 1, 0);
        total++; if (rec_data !== mk(7'h33, 1) || level !== 5'd1) begin $display("FAIL midrst_fresh got=%h/%0d exp=%h/1", rec_data, level, mk(7'h33, 1)); bad++; end
    endtask

    task automatic test_random();
        logic [RW-1:0] exp_head;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7, OL'($urandom_range(0, 2)),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
            exp_head = (exp_q.size() > 0) ? exp_q[0] : '0;
            total++; if (level !== 5'(exp_q.size())) begin $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", i, level, exp_q.size()); bad++; end
            total++; if (rec_valid !== (exp_q.size() > 0)) begin $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", i, rec_valid, exp_q.size() > 0); bad++; end
            total++; if (rec_data !== exp_head) begin $display("FAIL rnd_data cyc=%0d got=%h exp=%h", i, rec_data, exp_head); bad++; end
            total++; if (overflow !== m_ovf) begin $display("FAIL rnd_overflow cyc=%0d got=%0b exp=%0b", i, overflow, m_ovf); bad++; end
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_basic();
        test_saturate();
        test_gaps();
        test_full_push_pop();
        test_overflow();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
